// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock divider bank.
// Default widths and common divisor values at 100 MHz.
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEF  = 26;
  localparam int unsigned SYS_CLK_HZ = 100_000_000;
  localparam int unsigned DIV_1HZ    = 50_000_000;
  localparam int unsigned DIV_1KHZ   = 50_000;

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: counter, active/shadow divisor, square wave + tick.
// Ports: clk, rst_n, en, load, div, [sync_i if CLKDIV_SYNC_EN], clk_o, tick_o, pend_o.
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned RST_DIV = DIV_1HZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [DIV_W-1:0] RST_V = DIV_W'(RST_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic             pend_d, clk_d, tick_d;
  logic             idle, term, sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // act_q == 0 is idle, so the N-1 wrap never reaches the compare.
  assign idle = !en || (act_q == '0);
  assign term = (cnt_q == act_q - ONE);

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_o;
    tick_d = 1'b0;
    act_d  = act_q;
    pdiv_d = pdiv_q;
    pend_d = pend_o;
    if (idle) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (load) act_d = div;
    end else if (sync_w || term) begin
      // Half-period boundary: a fresh load beats the shadow.
      cnt_d = '0;
      if (sync_w) begin
        clk_d = 1'b0;
      end else begin
        clk_d  = ~clk_o;
        tick_d = ~clk_o;
      end
      if (load) begin
        act_d  = div;
        pend_d = 1'b0;
      end else if (pend_o) begin
        act_d  = pdiv_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      if (load) begin
        pdiv_d = div;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= RST_V;
      pdiv_q <= '0;
      pend_o <= 1'b0;
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pdiv_q <= pdiv_d;
      pend_o <= pend_d;
      clk_o  <= clk_d;
      tick_o <= tick_d;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable clock dividers / tick generators.
// Ports: clk, rst_n, en_i, load_i, div_i, [sync_i if CLKDIV_SYNC_EN], clk_o, tick_o, pend_o.
module clk_div_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned RST_DIV = DIV_1HZ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH-1:0]       load_i,
  input  logic [N_CH*DIV_W-1:0] div_i,
`ifdef CLKDIV_SYNC_EN
  input  logic                  sync_i,
`endif
  output logic [N_CH-1:0]       clk_o,
  output logic [N_CH-1:0]       tick_o,
  output logic [N_CH-1:0]       pend_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clkdiv_ch #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_i[c]),
      .load   (load_i[c]),
      .div    (div_i[c*DIV_W +: DIV_W]),
`ifdef CLKDIV_SYNC_EN
      .sync_i (sync_i),
`endif
      .clk_o  (clk_o[c]),
      .tick_o (tick_o[c]),
      .pend_o (pend_o[c])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with RST_DIV overridden to 4.
// Covers reset, shadow/coincident loads, idle paths, N=1, wide N, sync.
module tb_clk_div_bank;

  localparam int NC = 4;
  localparam int DW = 26;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NC-1:0]  en_i = '0;
  logic [NC-1:0]  load_i = '0;
  logic [NC*DW-1:0] div_i = '0;
  logic           sync_i = 1'b0;
  logic [NC-1:0]  clk_o, tick_o, pend_o;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_bank #(
    .N_CH    (NC),
    .DIV_W   (DW),
    .RST_DIV (4)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .load_i (load_i),
    .div_i  (div_i),
`ifdef CLKDIV_SYNC_EN
    .sync_i (sync_i),
`endif
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .pend_o (pend_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int ch, input int val);
    div_i[ch*DW +: DW] = DW'(val);
  endtask

  task automatic load(input int ch, input int val);
    set_div(ch, val);
    load_i[ch] = 1'b1;
    step(1);
    load_i[ch] = 1'b0;
  endtask

  // Edges until tick_o[ch] is seen; -1 if the bound expires.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick_o[ch] && n < 300);
    if (!tick_o[ch]) n = -1;
  endtask

  // Edges until clk_o[ch] equals v; -1 if the bound expires.
  task automatic wait_clk(input int ch, input logic v, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (clk_o[ch] !== v && n < 300);
    if (clk_o[ch] !== v) n = -1;
  endtask

  int n;
  int hi;
  int first [NC];

  initial begin
    // Reset defaults
    step(2);
    chk("rst_clk", int'(clk_o), 0);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_pend", int'(pend_o), 0);
    rst_n = 1'b1;
    step(1);
    en_i = 4'b0001;
    wait_tick(0, n);
    chk("t1_first_rise", n, 4);
    chk("t1_clk_hi", int'(clk_o[0]), 1);
    chk("t1_others", int'(clk_o[3:1]), 0);
    wait_clk(0, 1'b0, n);
    chk("t1_high_phase", n, 4);
    wait_tick(0, n);
    chk("t1_low_phase", n, 4);
    wait_tick(0, n);
    chk("t1_period", n, 8);
    chk("t1_other_ticks", int'(tick_o[3:1]), 0);

    // Shadow load on ch1
    load(1, 5);
    chk("t2_idle_load_pend", int'(pend_o[1]), 0);
    en_i[1] = 1'b1;
    wait_tick(1, n);
    chk("t2_rise_n5", n, 5);
    step(2);
    load(1, 2);
    chk("t2_pend_set", int'(pend_o[1]), 1);
    wait_clk(1, 1'b0, n);
    chk("t2_old_half_rest", n, 2);
    chk("t2_pend_clr", int'(pend_o[1]), 0);
    wait_clk(1, 1'b1, n);
    chk("t2_new_low", n, 2);
    wait_clk(1, 1'b0, n);
    chk("t2_new_high", n, 2);

    // Coincident load on terminal count
    step(1);
    load(1, 3);
    chk("t3_rise", int'(clk_o[1]), 1);
    chk("t3_tick", int'(tick_o[1]), 1);
    chk("t3_pend", int'(pend_o[1]), 0);
    wait_clk(1, 1'b0, n);
    chk("t3_high3", n, 3);
    wait_clk(1, 1'b1, n);
    chk("t3_low3", n, 3);

    // Load 0 on active ch2
    en_i[2] = 1'b1;
    wait_tick(2, n);
    chk("t4_ch2_rise", n, 4);
    step(1);
    load(2, 0);
    chk("t4_ch2_pend", int'(pend_o[2]), 1);
    wait_clk(2, 1'b0, n);
    chk("t4_ch2_fall", n, 2);
    chk("t4_ch2_pend_clr", int'(pend_o[2]), 0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      hi += int'(clk_o[2]) + int'(tick_o[2]);
    end
    chk("t4_ch2_idle", hi, 0);

    // Disable and re-enable ch3
    en_i[3] = 1'b1;
    wait_tick(3, n);
    chk("t4_ch3_rise", n, 4);
    step(1);
    en_i[3] = 1'b0;
    step(1);
    chk("t4_ch3_off", int'(clk_o[3]), 0);
    en_i[3] = 1'b1;
    wait_tick(3, n);
    chk("t4_ch3_restart", n, 4);

    // N = 1 on ch0
    en_i[0] = 1'b0;
    step(1);
    chk("t5_ch0_off", int'(clk_o[0]), 0);
    load(0, 1);
    en_i[0] = 1'b1;
    wait_tick(0, n);
    chk("t5_n1_rise", n, 1);
    step(1);
    chk("t5_n1_low", int'(clk_o[0]), 0);
    chk("t5_n1_notick", int'(tick_o[0]), 0);
    step(1);
    chk("t5_n1_high", int'(clk_o[0]), 1);
    chk("t5_n1_tick", int'(tick_o[0]), 1);

    // Wide divisor on ch1: no early toggle
    en_i[1] = 1'b0;
    step(1);
    load(1, 50_000_000);
    en_i[1] = 1'b1;
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      hi += int'(clk_o[1]);
    end
    chk("t5_wide_quiet", hi, 0);
    chk("t5_wide_pend", int'(pend_o[1]), 0);

`ifdef CLKDIV_SYNC_EN
    // Phase alignment
    en_i = '0;
    step(1);
    set_div(0, 3);
    set_div(1, 5);
    set_div(2, 7);
    set_div(3, 2);
    load_i = 4'b1111;
    step(1);
    load_i = '0;
    en_i = 4'b1111;
    step(13);
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    chk("t6_sync_clk", int'(clk_o), 0);
    chk("t6_sync_tick", int'(tick_o), 0);
    for (int c = 0; c < NC; c++) first[c] = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      for (int c = 0; c < NC; c++)
        if (tick_o[c] && first[c] == 0) first[c] = k;
    end
    chk("t6_rise_ch0", first[0], 3);
    chk("t6_rise_ch1", first[1], 5);
    chk("t6_rise_ch2", first[2], 7);
    chk("t6_rise_ch3", first[3], 2);
`endif

    // Asynchronous reset mid-operation
    wait_tick(3, n);
    chk("t7_ch3_rise", int'(n > 0), 1);
    load(3, 6);
    chk("t7_pend", int'(pend_o[3]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_clk", int'(clk_o), 0);
    chk("t7_rst_tick", int'(tick_o), 0);
    chk("t7_rst_pend", int'(pend_o), 0);
    step(1);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
